// File: rtl/mdu_hilo_pkg.sv
// +----------------------------------------------------------------------------
// | mdu_hilo_pkg
// | Operation codes and default latencies shared by the MDU, decode and hazard logic.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package mdu_hilo_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

`default_nettype wire

// File: rtl/mdu_divider.sv
// +----------------------------------------------------------------------------
// | mdu_divider
// | Combinational signed/unsigned 32-bit quotient/remainder with divide-by-zero flag.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mdu_divider (
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q;
  logic [31:0] w_r;

  // Divide magnitudes unsigned, then restore signs: quotient truncates toward
  // zero, remainder follows the dividend. 0x80000000 magnitude stays exact.
  assign w_neg_a  = is_signed & dividend[31];
  assign w_neg_b  = is_signed & divisor[31];
  assign w_mag_a  = w_neg_a ? (~dividend + 32'd1) : dividend;
  assign w_mag_b  = w_neg_b ? (~divisor + 32'd1) : divisor;
  assign div_zero = (divisor == 32'd0);

  assign w_q = div_zero ? 32'd0 : (w_mag_a / w_mag_b);
  assign w_r = div_zero ? 32'd0 : (w_mag_a % w_mag_b);

  assign quotient  = (w_neg_a ^ w_neg_b) ? (~w_q + 32'd1) : w_q;
  assign remainder = w_neg_a ? (~w_r + 32'd1) : w_r;

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// +----------------------------------------------------------------------------
// | mdu_hilo
// | EX-stage multiply/divide unit owning HI/LO, with fixed-latency busy window.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_MULT_LD = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        r_pend;
  logic               r_pend_wr;

  logic        w_accept;
  logic        w_mul_signed;
  logic [63:0] w_op_a;
  logic [63:0] w_op_b;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div_zero;

  assign w_accept = start & ~r_busy & (md_op != MD_NONE);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both MULT and MULTU.
  assign w_mul_signed = (md_op == MD_MULT);
  assign w_op_a = {{32{w_mul_signed & rs_val[31]}}, rs_val};
  assign w_op_b = {{32{w_mul_signed & rt_val[31]}}, rt_val};
  assign w_prod = w_op_a * w_op_b;

  mdu_divider u_div (
    .is_signed (md_op == MD_DIV),
    .dividend  (rs_val),
    .divisor   (rt_val),
    .quotient  (w_quo),
    .remainder (w_rem),
    .div_zero  (w_div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend    <= '0;
      r_pend_wr <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - c_CNT_ONE;
      if (r_cnt == c_CNT_ONE) begin
        r_busy <= 1'b0;
        if (r_pend_wr) begin
          r_hi <= r_pend[63:32];
          r_lo <= r_pend[31:0];
        end
      end
    end else if (w_accept) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          r_pend    <= w_prod;
          r_pend_wr <= 1'b1;
          r_cnt     <= c_MULT_LD;
          r_busy    <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          r_pend    <= {w_rem, w_quo};
          r_pend_wr <= ~w_div_zero;
          r_cnt     <= c_DIV_LD;
          r_busy    <= 1'b1;
        end
        MD_MTHI: r_hi <= rs_val;
        MD_MTLO: r_lo <= rs_val;
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// +----------------------------------------------------------------------------
// | tb_mdu_hilo
// | Self-checking bench: vector table with scoreboard plus busy/reset corner sequences.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t vt[16];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
  endtask

  // Counts busy samples, starting with the cycle right after the accept edge.
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   n;
    e = sb.pop_front();
    wait_done(n);
    chk({tag, " busy_cycles"}, 32'(n), 32'(e.cyc));
    chk({tag, " hi"}, hi, e.hi);
    chk({tag, " lo"}, lo, e.lo);
  endtask

  initial begin
    int n;

    vt[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vt[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
    vt[2]  = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MC};
    vt[3]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vt[4]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vt[5]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vt[6]  = '{MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
    vt[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vt[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    vt[9]  = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DC};
    vt[10] = '{MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, DC};
    vt[11] = '{MD_MTHI,  32'h00001234, 32'hAAAAAAAA, 32'h00001234, 32'h7FFFFFFC, 0};
    vt[12] = '{MD_MTLO,  32'h00005678, 32'h55555555, 32'h00001234, 32'h00005678, 0};
    vt[13] = '{MD_DIV,   32'd5,        32'd0,        32'h00001234, 32'h00005678, DC};
    vt[14] = '{MD_DIVU,  32'd9,        32'd0,        32'h00001234, 32'h00005678, DC};
    vt[15] = '{MD_MULT,  32'd0,        32'h00012345, 32'h00000000, 32'h00000000, MC};

    reset = 1'b0; start = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      sb.push_back('{vt[i].hi, vt[i].lo, vt[i].cyc});
      issue(vt[i].op, vt[i].rs, vt[i].rt);
      drain($sformatf("vec%0d", i));
    end

    // Requests raised while busy must all be dropped; the one held through the
    // final busy cycle lands on the first idle edge.
    issue(MD_MULT, 32'h10, 32'h20);
    n = busy ? 1 : 0;
    while (busy && n < 200) begin
      @(negedge clk);
      start = 1'b1;
      if (n < MC) begin
        md_op  = n[0] ? MD_MTLO : MD_MULT;
        rs_val = n[0] ? 32'hDEAD : 32'h99;
        rt_val = 32'h77;
      end else begin
        md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd4;
      end
      @(posedge clk); #1;
      if (busy) n++;
    end
    chk("ign busy_cycles", 32'(n), 32'(MC));
    chk("ign hi", hi, 32'h0);
    chk("ign lo", lo, 32'h200);
    @(posedge clk); #1;
    chk("b2b accept busy", {31'd0, busy}, 32'd1);
    start = 1'b0; md_op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
    wait_done(n);
    chk("b2b busy_cycles", 32'(n), 32'(MC));
    chk("b2b hi", hi, 32'h0);
    chk("b2b lo", lo, 32'd12);

    // Asynchronous reset in the middle of a divide.
    issue(MD_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("div c3 busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst hi", hi, 32'd0);
    chk("async rst lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post rst c%0d busy", c), {31'd0, busy}, 32'd0);
      chk($sformatf("post rst c%0d hi", c), hi, 32'd0);
      chk($sformatf("post rst c%0d lo", c), lo, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
